// File: rtl/collision_pkg.sv
// Shared types and constants for the collision frame scanner and its accumulator.
package collision_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int FLAG_DOWN  = 0;
  localparam int FLAG_UP    = 1;
  localparam int FLAG_RIGHT = 2;
  localparam int FLAG_LEFT  = 3;

endpackage

// File: rtl/collision_acc.sv
// Aligns checker flags with table occupancy, ORs them into a frame result and,
// with COLLISION_SCAN_FIRST_HIT_EN, records the lowest tile index with floor contact.
module collision_acc
  import collision_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             issue,
  input  logic             commit,
  input  logic             tile_vld,
  input  logic [3:0]       chk_flags,
`ifdef COLLISION_SCAN_FIRST_HIT_EN
  input  logic [IDX_W-1:0] tile_addr,
  output logic [IDX_W-1:0] first_floor_idx,
  output logic             first_floor_vld,
`endif
  output logic [3:0]       contact
);

  // v_data lines up with ROM data, v_flag with the registered checker output.
  logic       v_data;
  logic       v_flag;
  logic       tv_flag;
  logic [3:0] acc;
  logic [3:0] masked;
  logic [3:0] acc_nxt;

  always_comb begin
    masked  = (v_flag && tv_flag) ? chk_flags : '0;
    acc_nxt = acc | masked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_data  <= 1'b0;
      v_flag  <= 1'b0;
      tv_flag <= 1'b0;
      acc     <= '0;
      contact <= '0;
    end else begin
      v_data  <= issue;
      v_flag  <= v_data;
      tv_flag <= tile_vld & v_data;
      acc     <= clear ? '0 : acc_nxt;
      // The final tile's flags arrive in the commit cycle, so publish acc_nxt.
      if (commit) contact <= acc_nxt;
    end
  end

`ifdef COLLISION_SCAN_FIRST_HIT_EN
  logic [IDX_W-1:0] idx_data;
  logic [IDX_W-1:0] idx_flag;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_vld;
  logic             down_new;

  assign down_new = masked[FLAG_DOWN] & ~hit_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_data        <= '0;
      idx_flag        <= '0;
      hit_idx         <= '0;
      hit_vld         <= 1'b0;
      first_floor_idx <= '0;
      first_floor_vld <= 1'b0;
    end else begin
      idx_data <= tile_addr;
      idx_flag <= idx_data;
      if (clear) begin
        hit_idx <= '0;
        hit_vld <= 1'b0;
      end else if (down_new) begin
        hit_idx <= idx_flag;
        hit_vld <= 1'b1;
      end
      if (commit) begin
        first_floor_idx <= down_new ? idx_flag : hit_idx;
        first_floor_vld <= hit_vld | masked[FLAG_DOWN];
      end
    end
  end
`endif

endmodule

// File: rtl/collision_scan.sv
// Frame scheduler sharing one collision checker across the tile table.
// Optional first-floor-hit outputs are enabled by COLLISION_SCAN_FIRST_HIT_EN.
module collision_scan
  import collision_pkg::*;
#(
  parameter int N_TILES = 32,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [X_W-1:0]   x_blue,
  input  logic [Y_W-1:0]   y_blue,
  output logic [IDX_W-1:0] tile_addr,
  input  logic [X_W-1:0]   tile_x,
  input  logic [Y_W-1:0]   tile_y,
  input  logic             tile_vld,
  output logic [X_W-1:0]   chk_x_blue,
  output logic [Y_W-1:0]   chk_y_blue,
  output logic [X_W-1:0]   chk_x_ground,
  output logic [Y_W-1:0]   chk_y_ground,
  input  logic [3:0]       chk_flags,
`ifdef COLLISION_SCAN_FIRST_HIT_EN
  output logic [IDX_W-1:0] first_floor_idx,
  output logic             first_floor_vld,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       contact
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(N_TILES - 1);

  state_t state;
  logic   drain_cnt;
  logic   issue;
  logic   clear;
  logic   commit;

  assign chk_x_ground = tile_x;
  assign chk_y_ground = tile_y;

  assign issue  = (state == SCAN);
  assign clear  = (state == IDLE) && start;
  assign commit = (state == DRAIN) && drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tile_addr  <= '0;
      chk_x_blue <= '0;
      chk_y_blue <= '0;
      drain_cnt  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SCAN;
            chk_x_blue <= x_blue;
            chk_y_blue <= y_blue;
            tile_addr  <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (tile_addr == LAST_ADDR) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            tile_addr <= tile_addr + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  collision_acc #(
    .IDX_W(IDX_W)
  ) u_acc (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .issue           (issue),
    .commit          (commit),
    .tile_vld        (tile_vld),
    .chk_flags       (chk_flags),
`ifdef COLLISION_SCAN_FIRST_HIT_EN
    .tile_addr       (tile_addr),
    .first_floor_idx (first_floor_idx),
    .first_floor_vld (first_floor_vld),
`endif
    .contact         (contact)
  );

endmodule

// File: tb/tb_collision_scan.sv
// Directed bench: a 4-tile instance for timing/masking and a 32-tile instance
// for snapshot hold, first floor hit and mid-scan reset.
module tb_collision_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- 4-tile instance ----------------
  logic       rst4 = 1'b1, start4 = 1'b0;
  logic [9:0] xb4 = '0;
  logic [8:0] yb4 = '0;
  logic [1:0] addr4;
  logic [9:0] tx4, cxb4, cxg4;
  logic [8:0] ty4, cyb4, cyg4;
  logic       tv4;
  logic [3:0] cf4;
  logic       busy4, done4;
  logic [3:0] contact4;
  logic       force4 = 1'b0;
  logic [9:0] rx4 [4];
  logic [8:0] ry4 [4];
  logic       rv4 [4];
`ifdef COLLISION_SCAN_FIRST_HIT_EN
  logic [1:0] ffi4;
  logic       ffv4;
`endif

  collision_scan #(.N_TILES(4), .IDX_W(2)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .x_blue(xb4), .y_blue(yb4),
    .tile_addr(addr4), .tile_x(tx4), .tile_y(ty4), .tile_vld(tv4),
    .chk_x_blue(cxb4), .chk_y_blue(cyb4), .chk_x_ground(cxg4), .chk_y_ground(cyg4),
    .chk_flags(cf4),
`ifdef COLLISION_SCAN_FIRST_HIT_EN
    .first_floor_idx(ffi4), .first_floor_vld(ffv4),
`endif
    .busy(busy4), .done(done4), .contact(contact4));

  // Toy checker: down when tile is 1..48 below player, up when 1..48 above, |dx|<=16.
  function automatic logic [3:0] geo(input int xb, input int yb, input int xg, input int yg);
    int dx, dy;
    logic [3:0] f;
    dx = xg - xb;
    dy = yg - yb;
    f = '0;
    if (dx <= 16 && dx >= -16) begin
      if (dy > 0 && dy <= 48) f[0] = 1'b1;
      if (dy < 0 && dy >= -48) f[1] = 1'b1;
    end
    return f;
  endfunction

  always @(posedge clk) begin
    tx4 <= rx4[addr4];
    ty4 <= ry4[addr4];
    tv4 <= rv4[addr4];
    cf4 <= force4 ? 4'hF : geo(int'(cxb4), int'(cyb4), int'(cxg4), int'(cyg4));
  end

  // ---------------- 32-tile instance ----------------
  logic       rst32 = 1'b1, start32 = 1'b0;
  logic [9:0] xb32 = '0;
  logic [8:0] yb32 = '0;
  logic [4:0] addr32;
  logic [9:0] tx32, cxb32, cxg32;
  logic [8:0] ty32, cyb32, cyg32;
  logic       tv32;
  logic [3:0] cf32;
  logic       busy32, done32;
  logic [3:0] contact32;
  logic [3:0] ftab [32];
  logic       rv32 [32];
`ifdef COLLISION_SCAN_FIRST_HIT_EN
  logic [4:0] ffi32;
  logic       ffv32;
`endif

  collision_scan #(.N_TILES(32), .IDX_W(5)) u32 (
    .clk(clk), .rst(rst32), .start(start32), .x_blue(xb32), .y_blue(yb32),
    .tile_addr(addr32), .tile_x(tx32), .tile_y(ty32), .tile_vld(tv32),
    .chk_x_blue(cxb32), .chk_y_blue(cyb32), .chk_x_ground(cxg32), .chk_y_ground(cyg32),
    .chk_flags(cf32),
`ifdef COLLISION_SCAN_FIRST_HIT_EN
    .first_floor_idx(ffi32), .first_floor_vld(ffv32),
`endif
    .busy(busy32), .done(done32), .contact(contact32));

  // Tile i sits at x=i; the checker looks its flags up by ground x.
  always @(posedge clk) begin
    tx32 <= {5'd0, addr32};
    ty32 <= 9'd50;
    tv32 <= rv32[addr32];
    cf32 <= ftab[cxg32[4:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start so the next edge is E0; return in cycle 1.
  task automatic go4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic scan4(input string tag, input logic [3:0] exp_c);
    go4();
    for (int c = 1; c <= 6; c++) begin
      check({tag, "_nodone"}, 32'(done4), 32'd0);
      tick();
    end
    check({tag, "_done7"}, 32'(done4), 32'd1);
    check({tag, "_contact"}, 32'(contact4), 32'(exp_c));
    check({tag, "_busy7"}, 32'(busy4), 32'd1);
    tick();
    check({tag, "_idle"}, 32'(busy4), 32'd0);
    check({tag, "_hold"}, 32'(contact4), 32'(exp_c));
  endtask

  initial begin
    int ndone;
    int cyc;

    // Table for the 4-tile instance: only tile1 occupied.
    rx4[0] = 10'd90;  ry4[0] = 9'd130; rv4[0] = 1'b0;
    rx4[1] = 10'd100; ry4[1] = 9'd200; rv4[1] = 1'b1;
    rx4[2] = 10'd500; ry4[2] = 9'd400; rv4[2] = 1'b0;
    rx4[3] = 10'd500; ry4[3] = 9'd400; rv4[3] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ftab[i] = 4'h0;
      rv32[i] = 1'b0;
    end
    ftab[1] = 4'b0001;                 // down but empty slot
    ftab[2] = 4'b1000; rv32[2] = 1'b1; // left
    rv32[3] = 1'b1;
    ftab[5] = 4'b0001; rv32[5] = 1'b1; // first floor
    ftab[9] = 4'b0001; rv32[9] = 1'b1;
    ftab[12] = 4'b0010;                // up but empty slot

    repeat (3) tick();
    rst4 = 1'b0;
    rst32 = 1'b0;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_contact", 32'(contact4), 32'd0);
    check("rst_addr", 32'(addr4), 32'd0);
    check("rst_snap", 32'(cxb32), 32'd0);

    // Basic hit.
    xb4 = 10'd90; yb4 = 9'd160;
    scan4("hit", 4'b0001);
    check("hit_snap_x", 32'(cxb4), 32'd90);
    check("hit_snap_y", 32'(cyb4), 32'd160);

    // Empty table with a checker that always reports contact.
    rv4[1] = 1'b0;
    force4 = 1'b1;
    scan4("empty", 4'b0000);

    // Occupied tile with all flags set.
    rv4[2] = 1'b1;
    scan4("full", 4'b1111);
    force4 = 1'b0;
    rv4[2] = 1'b0;
    rv4[1] = 1'b1;

    // Start while busy (cycle 3) and in DONE (cycle 7) is ignored.
    ndone = 0;
    go4();
    for (int c = 1; c <= 25; c++) begin
      ndone += int'(done4);
      start4 = (c == 3 || c == 7);
      tick();
    end
    start4 = 1'b0;
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_busy", 32'(busy4), 32'd0);
    check("ign_contact", 32'(contact4), 32'd1);
    scan4("rescan", 4'b0001);

    // 32 tiles: first floor hit plus snapshot hold while x_blue moves.
    xb32 = 10'd300; yb32 = 9'd100;
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    xb32 = 10'd7;
    cyc = 1;
    while (!done32 && cyc < 60) begin
      check("snap_x", 32'(cxb32), 32'd300);
      if (cyc == 10) check("addr_c10", 32'(addr32), 32'd9);
      tick();
      cyc++;
    end
    check("fh_done_cycle", 32'(cyc), 32'd35);
    check("fh_contact", 32'(contact32), 32'b1001);
    check("fh_addr_hold", 32'(addr32), 32'd31);
`ifdef COLLISION_SCAN_FIRST_HIT_EN
    check("fh_idx", 32'(ffi32), 32'd5);
    check("fh_vld", 32'(ffv32), 32'd1);
`endif
    tick();
    check("fh_idle", 32'(busy32), 32'd0);

    // Reset in cycle 10 of a scan.
    xb32 = 10'd44;
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (9) tick();
    check("rmid_busy_before", 32'(busy32), 32'd1);
    rst32 = 1'b1;
    tick();
    rst32 = 1'b0;
    check("rmid_busy", 32'(busy32), 32'd0);
    check("rmid_contact", 32'(contact32), 32'd0);
    check("rmid_addr", 32'(addr32), 32'd0);
    check("rmid_snap", 32'(cxb32), 32'd0);
`ifdef COLLISION_SCAN_FIRST_HIT_EN
    check("rmid_ffv", 32'(ffv32), 32'd0);
    check("rmid_ffi", 32'(ffi32), 32'd0);
`endif
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      ndone += int'(done32);
      tick();
    end
    check("rmid_nodone", 32'(ndone), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
